// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR_LO  = 4'd1,
    ST_HDR_HI  = 4'd2,
    ST_DATA_LO = 4'd3,
    ST_DATA_HI = 4'd4,
    ST_CHK     = 4'd5,
    ST_FILL    = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_e;

  localparam logic [15:0] HALT_INSTR = 16'hE000;
  localparam int          HDR_BYTES  = 2;
  // word index to byte address: each word occupies 4 bytes of address space
  localparam int          ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_xor_csum.sv
// imem_xor_csum: 8-bit running XOR over accepted stream bytes.
module imem_xor_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  // accumulate bytes; clear wins over enable so a new load starts from zero
  always_ff @(posedge clk) begin
    if (reset || clear) csum <= 8'h00;
    else if (en)        csum <= csum ^ din;
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory programmer. Assembles a
// little-endian byte stream into instructions, writes them, pads the rest
// of memory with HALT and releases the core once the image is in place.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect and verify a
// trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | waiting for start after reset
// HDR_LO  | waiting for word-count low byte
// HDR_HI  | waiting for word-count high byte; range check
// DATA_LO | waiting for instruction low byte
// DATA_HI | waiting for instruction high byte; issues write
// CHK     | waiting for checksum byte (checksum build only)
// FILL    | writing HALT to the remaining words, one per cycle
// DONE    | image complete, core released
// ERR     | load aborted, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int INSTR_W   = 16,
  parameter int ADDR_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [INSTR_W-1:0] wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam int IDX_W = $clog2(MEM_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(MEM_WORDS);

  localparam logic [3:0] IDLE    = ST_IDLE;
  localparam logic [3:0] HDR_LO  = ST_HDR_LO;
  localparam logic [3:0] HDR_HI  = ST_HDR_HI;
  localparam logic [3:0] DATA_LO = ST_DATA_LO;
  localparam logic [3:0] DATA_HI = ST_DATA_HI;
  localparam logic [3:0] FILL    = ST_FILL;
  localparam logic [3:0] DONE    = ST_DONE;
  localparam logic [3:0] ERR     = ST_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [3:0] CHK     = ST_CHK;
  localparam logic [3:0] AFTER_BODY = CHK;
`else
  localparam logic [3:0] AFTER_BODY = FILL;
`endif

  logic [3:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [15:0]      nwords;
  logic [7:0]       lo_byte;
  logic [15:0]      hdr_n;
  logic             xfer;
  logic             last_word;
  logic             can_start;

  assign xfer      = rx_valid & rx_ready;
  assign idx_inc   = idx + 1'b1;
  assign hdr_n     = {rx_data, lo_byte};
  assign last_word = (16'(idx_inc) == nwords);
  assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);

  assign cpu_reset = (state != DONE);
  assign done      = (state == DONE);
  assign error     = (state == ERR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_clr;
  logic       csum_en;

  // checksum byte itself is not accumulated; it is compared against the sum
  assign csum_clr = start & can_start;
  assign csum_en  = xfer & (state != CHK);

  imem_xor_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (csum_clr),
    .en    (csum_en),
    .din   (rx_data),
    .csum  (csum)
  );

  assign rx_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA_LO) ||
                    (state == DATA_HI) || (state == CHK);
`else
  assign rx_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA_LO) ||
                    (state == DATA_HI);
`endif

  // sequencing, byte assembly and the registered memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      nwords  <= '0;
      lo_byte <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state <= HDR_LO;
            idx   <= '0;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            lo_byte <= rx_data;
            state   <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            nwords <= hdr_n;
            if (hdr_n > 16'(MEM_WORDS)) state <= ERR;
            else if (hdr_n != 16'h0000) state <= DATA_LO;
            else                        state <= AFTER_BODY;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            lo_byte <= rx_data;
            state   <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (xfer) begin
            we    <= 1'b1;
            waddr <= ADDR_W'(idx) << ADDR_SHIFT;
            wdata <= INSTR_W'({rx_data, lo_byte});
            idx   <= idx_inc;
            state <= last_word ? AFTER_BODY : DATA_LO;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) state <= ((csum ^ rx_data) != 8'h00) ? ERR : FILL;
        end
`endif
        FILL: begin
          // idx already at the end means no padding is left (full image)
          if (idx == IDX_END) begin
            state <= DONE;
          end else begin
            we    <= 1'b1;
            waddr <= ADDR_W'(idx) << ADDR_SHIFT;
            wdata <= INSTR_W'(HALT_INSTR);
            idx   <= idx_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
